// File: rtl/seq_divider_unit.sv
// seq_divider_unit: sequential signed/unsigned integer divider.
// Non-restoring iteration retires one quotient bit per cycle. Valid/ready
// handshakes on request and result. Divide-by-zero and signed MIN / -1
// produce fixed results and set a flag.
module seq_divider_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic             mode;       // latched signed_mode
    logic [WIDTH-1:0] acc;        // dividend, then its magnitude, then quotient bits (A)
    logic [WIDTH-1:0] dvs;        // divisor, then its magnitude (D)
    logic [WIDTH:0]   part;       // signed partial remainder (P)
    logic [CNT_W-1:0] cnt;        // remaining iteration steps
    logic             neg_quo;    // quotient must be negated at the end
    logic             neg_rem;    // remainder must be negated at the end
    logic             zero_div;   // accepted divisor was zero
    logic             min_ovf;    // accepted operands were signed MIN / -1

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] r_mag;

    // One non-restoring step and the final remainder correction.
    always_comb begin
        p_shift = {part[WIDTH-1:0], acc[WIDTH-1]};
        p_step  = part[WIDTH] ? (p_shift + {1'b0, dvs}) : (p_shift - {1'b0, dvs});
        // Corrected remainder lies in [0, D), so WIDTH-bit modular add is exact.
        r_mag   = part[WIDTH] ? (part[WIDTH-1:0] + dvs) : part[WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; req_ready depends on state only.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = PREP;
                end
            end
            PREP: begin
                // Special cases are classified on accept and retired from PREP,
                // giving them a fixed one-cycle result latency.
                if (zero_div || min_ovf) begin
                    state_next = DONE;
                end else begin
                    state_next = ITER;
                end
            end
            ITER: begin
                if (cnt == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            mode        <= 1'b0;
            acc         <= '0;
            dvs         <= '0;
            part        <= '0;
            cnt         <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            zero_div    <= 1'b0;
            min_ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        mode     <= signed_mode;
                        acc      <= dividend;
                        dvs      <= divisor;
                        zero_div <= (divisor == '0);
                        min_ovf  <= signed_mode
                                    && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                    && (divisor == '1);
                    end
                end
                PREP: begin
                    if (zero_div) begin
                        quotient    <= '1;
                        remainder   <= acc;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                        res_valid   <= 1'b1;
                    end else if (min_ovf) begin
                        quotient    <= acc;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b1;
                        res_valid   <= 1'b1;
                    end else begin
                        // |MIN| = 2^(WIDTH-1) still fits WIDTH bits as unsigned.
                        acc     <= (mode && acc[WIDTH-1]) ? -acc : acc;
                        dvs     <= (mode && dvs[WIDTH-1]) ? -dvs : dvs;
                        neg_quo <= mode && (acc[WIDTH-1] ^ dvs[WIDTH-1]);
                        neg_rem <= mode && acc[WIDTH-1];
                        part    <= '0;
                        cnt     <= CNT_W'(WIDTH - 1);
                    end
                end
                ITER: begin
                    part <= p_step;
                    acc  <= {acc[WIDTH-2:0], ~p_step[WIDTH]};
                    cnt  <= cnt - CNT_W'(1);
                end
                FIX: begin
                    quotient    <= neg_quo ? -acc : acc;
                    remainder   <= neg_rem ? -r_mag : r_mag;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    res_valid   <= 1'b1;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_unit.sv
// Testbench for seq_divider_unit: a WIDTH=32 and a WIDTH=8 instance checked
// against a cycle-level arithmetic model plus hand-computed directed vectors.
module tb_seq_divider_unit;

    logic clk;
    logic rst;

    // Per-instance stimulus: index 0 = WIDTH 32, index 1 = WIDTH 8
    logic        rv [2];
    logic        sm [2];
    logic        rr [2];
    logic [63:0] a_in [2];
    logic [63:0] b_in [2];

    logic        rdy32, val32, dz32, ov32;
    logic [31:0] q32, r32;
    logic        rdy8, val8, dz8, ov8;
    logic [7:0]  q8, r8;

    logic        o_rdy [2];
    logic        o_val [2];
    logic        o_dz  [2];
    logic        o_ov  [2];
    logic [63:0] o_q   [2];
    logic [63:0] o_r   [2];

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    seq_divider_unit #(.WIDTH(32)) u_div32 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (rv[0]),
        .req_ready   (rdy32),
        .signed_mode (sm[0]),
        .dividend    (a_in[0][31:0]),
        .divisor     (b_in[0][31:0]),
        .res_valid   (val32),
        .res_ready   (rr[0]),
        .quotient    (q32),
        .remainder   (r32),
        .div_by_zero (dz32),
        .overflow    (ov32)
    );

    seq_divider_unit #(.WIDTH(8)) u_div8 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (rv[1]),
        .req_ready   (rdy8),
        .signed_mode (sm[1]),
        .dividend    (a_in[1][7:0]),
        .divisor     (b_in[1][7:0]),
        .res_valid   (val8),
        .res_ready   (rr[1]),
        .quotient    (q8),
        .remainder   (r8),
        .div_by_zero (dz8),
        .overflow    (ov8)
    );

    always_comb begin
        o_rdy[0] = rdy32; o_val[0] = val32; o_dz[0] = dz32; o_ov[0] = ov32;
        o_q[0] = {32'd0, q32}; o_r[0] = {32'd0, r32};
        o_rdy[1] = rdy8;  o_val[1] = val8;  o_dz[1] = dz8;  o_ov[1] = ov8;
        o_q[1] = {56'd0, q8};  o_r[1] = {56'd0, r8};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: truncating division, remainder follows dividend.
    function automatic void model(input int w, input bit s, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] q,
                                  output logic [63:0] r, output bit dz, output bit ov,
                                  output int l);
        logic [63:0] mask;
        logic [63:0] minv;
        longint sa, sb, tq, tr;
        mask = (64'd1 << w) - 64'd1;
        minv = 64'd1 << (w - 1);
        dz = 0;
        ov = 0;
        l = w + 2;
        q = '0;
        r = '0;
        if (b == 64'd0) begin
            q = mask; r = a; dz = 1; l = 1;
        end else if (s && a == minv && b == mask) begin
            q = a; r = 64'd0; ov = 1; l = 1;
        end else if (s) begin
            sa = ((a & minv) != 64'd0) ? (longint'(a) - longint'(64'd1 << w)) : longint'(a);
            sb = ((b & minv) != 64'd0) ? (longint'(b) - longint'(64'd1 << w)) : longint'(b);
            tq = sa / sb;
            tr = sa % sb;
            q = 64'(tq) & mask;
            r = 64'(tr) & mask;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Cycle-level model state
    int          wd [2] = '{32, 8};
    string       tag [2] = '{"32", "8"};
    bit          busy [2];
    bit          exp_valid [2];
    int          acc_cyc [2];
    int          lat [2];
    logic [63:0] eq [2];
    logic [63:0] er [2];
    bit          edz [2];
    bit          eov [2];
    int          cyc = 0;

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                busy[i] = 0;
            end else if (busy[i]) begin
                if (exp_valid[i] && rr[i]) busy[i] = 0;
            end else if (rv[i]) begin
                busy[i] = 1;
                acc_cyc[i] = cyc;
                model(wd[i], sm[i], a_in[i], b_in[i], eq[i], er[i], edz[i], eov[i], lat[i]);
            end
            exp_valid[i] = busy[i] && ((cyc - acc_cyc[i]) >= lat[i]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk({"m_ready", tag[i]}, 64'(o_rdy[i]), 64'(!busy[i]));
                chk({"m_valid", tag[i]}, 64'(o_val[i]), 64'(exp_valid[i]));
                if (exp_valid[i]) begin
                    chk({"m_quot", tag[i]}, o_q[i], eq[i]);
                    chk({"m_rem", tag[i]}, o_r[i], er[i]);
                    chk({"m_dz", tag[i]}, 64'(o_dz[i]), 64'(edz[i]));
                    chk({"m_ovf", tag[i]}, 64'(o_ov[i]), 64'(eov[i]));
                end
            end
        end
    end

    task automatic run_op(input int i, input bit s, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] xq, input logic [63:0] xr, input bit xdz,
                          input bit xov, input int xlat, input int hold);
        int k;
        sm[i] = s; a_in[i] = a; b_in[i] = b; rv[i] = 1'b1; rr[i] = 1'b0;
        k = 0;
        while (!o_rdy[i] && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk({"accept_ready", tag[i]}, 64'(o_rdy[i]), 64'd1);
        @(posedge clk); #1;
        rv[i] = 1'b0;
        k = 0;
        while (!o_val[i] && k < 200) begin
            @(posedge clk); #1; k++;
        end
        chk({"latency", tag[i]}, 64'(k), 64'(xlat));
        chk({"quot", tag[i]}, o_q[i], xq);
        chk({"rem", tag[i]}, o_r[i], xr);
        chk({"dz", tag[i]}, 64'(o_dz[i]), 64'(xdz));
        chk({"ovf", tag[i]}, 64'(o_ov[i]), 64'(xov));
        repeat (hold) begin
            @(posedge clk); #1;
            chk({"hold_valid", tag[i]}, 64'(o_val[i]), 64'd1);
            chk({"hold_ready", tag[i]}, 64'(o_rdy[i]), 64'd0);
            chk({"hold_quot", tag[i]}, o_q[i], xq);
            chk({"hold_rem", tag[i]}, o_r[i], xr);
        end
        rr[i] = 1'b1;
        @(posedge clk); #1;
        rr[i] = 1'b0;
        chk({"release_valid", tag[i]}, 64'(o_val[i]), 64'd0);
        chk({"release_ready", tag[i]}, 64'(o_rdy[i]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; sm[i] = 1'b0; rr[i] = 1'b0; a_in[i] = '0; b_in[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk({"rst_ready", tag[i]}, 64'(o_rdy[i]), 64'd1);
            chk({"rst_valid", tag[i]}, 64'(o_val[i]), 64'd0);
            chk({"rst_quot", tag[i]}, o_q[i], 64'd0);
            chk({"rst_rem", tag[i]}, o_r[i], 64'd0);
            chk({"rst_dz", tag[i]}, 64'(o_dz[i]), 64'd0);
            chk({"rst_ovf", tag[i]}, 64'(o_ov[i]), 64'd0);
        end
        chk_en = 1;

        //     inst sgn dividend        divisor         quotient        remainder       dz ov lat hold
        run_op(0, 0, 64'd100,        64'd7,          64'd14,         64'd2,          0, 0, 34, 0);
        run_op(0, 1, 64'hFFFFFFF9,   64'd2,          64'hFFFFFFFD,   64'hFFFFFFFF,   0, 0, 34, 0);
        run_op(0, 1, 64'd7,          64'hFFFFFFFE,   64'hFFFFFFFD,   64'd1,          0, 0, 34, 0);
        run_op(0, 0, 64'h12345678,   64'd0,          64'hFFFFFFFF,   64'h12345678,   1, 0, 1,  0);
        run_op(0, 1, 64'h80000000,   64'hFFFFFFFF,   64'h80000000,   64'd0,          0, 1, 1,  0);
        run_op(0, 0, 64'h80000000,   64'hFFFFFFFF,   64'd0,          64'h80000000,   0, 0, 34, 0);
        run_op(0, 0, 64'd1000,       64'd3,          64'd333,        64'd1,          0, 0, 34, 5);
        run_op(0, 1, 64'h80000000,   64'd1,          64'h80000000,   64'd0,          0, 0, 34, 0);
        run_op(0, 0, 64'hFFFFFFFF,   64'hFFFFFFFE,   64'd1,          64'd1,          0, 0, 34, 0);

        // Reset in the middle of iteration abandons the operation
        sm[0] = 1'b0; a_in[0] = 64'd1000; b_in[0] = 64'd3; rv[0] = 1'b1;
        chk("midrst_pre_ready", 64'(o_rdy[0]), 64'd1);
        @(posedge clk); #1;
        rv[0] = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("midrst_busy_ready", 64'(o_rdy[0]), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", 64'(o_rdy[0]), 64'd1);
        chk("midrst_valid", 64'(o_val[0]), 64'd0);
        chk("midrst_quot", o_q[0], 64'd0);
        chk("midrst_rem", o_r[0], 64'd0);
        chk("midrst_dz", 64'(o_dz[0]), 64'd0);
        chk("midrst_ovf", 64'(o_ov[0]), 64'd0);

        run_op(1, 0, 64'hFF, 64'h01, 64'hFF, 64'h00, 0, 0, 10, 0);
        run_op(1, 1, 64'h80, 64'h03, 64'hD6, 64'hFE, 0, 0, 10, 0);
        run_op(1, 1, 64'h80, 64'hFF, 64'h80, 64'h00, 0, 1, 1,  0);
        run_op(1, 0, 64'h80, 64'hFF, 64'h00, 64'h80, 0, 0, 10, 2);
        run_op(1, 0, 64'h5A, 64'h00, 64'hFF, 64'h5A, 1, 0, 1,  0);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
